// File: rtl/dii_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : dii_reg_responder
// Description : DII ring endpoint that serves the base registers, forwards
//               module addresses to a local register bus and returns replies.
// Revision    : 1.0 - initial release
// ============================================================================
module dii_reg_responder #(
    parameter logic [15:0] MOD_VENDOR  = 16'h0001,
    parameter logic [15:0] MOD_TYPE    = 16'h0000,
    parameter logic [15:0] MOD_VERSION = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] id,
    input  logic [15:0] in_data,
    input  logic        in_first,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] out_data,
    output logic        out_first,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] event_dest,
    output logic        reg_request,
    output logic        reg_write,
    output logic [15:0] reg_addr,
    output logic [15:0] reg_wdata,
    input  logic        reg_ack,
    input  logic        reg_err,
    input  logic [15:0] reg_rdata
);

    typedef enum logic [1:0] {
        ST_RX     = 2'd0,
        ST_DECODE = 2'd1,
        ST_ACCESS = 2'd2,
        ST_TX     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [2:0]  r_flit_cnt;
    logic [15:0] r_src;
    logic [5:0]  r_hdr;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic        r_write;
    logic        r_err;
    logic [15:0] r_rdata;
    logic [1:0]  r_tx_idx;
    logic [15:0] r_event_dest;
    logic        r_in_ready;

    logic [2:0]  w_rx_idx;
    logic        w_rx_accept;
    logic        w_is_write;
    logic        w_fmt_ok;
    logic        w_drop;
    logic        w_err;
    logic        w_access;
    logic        w_ed_write;
    logic [15:0] w_rdata;
    logic [3:0]  w_rsp_sub;
    logic [1:0]  w_tx_last_idx;
    logic        w_tx_done;

    assign w_rx_idx    = in_first ? 3'd0 : r_flit_cnt;
    assign w_rx_accept = (r_state == ST_RX) && r_in_ready && in_valid;
    assign w_is_write  = (r_hdr[3:0] == 4'd4);
    assign w_fmt_ok    = ((r_hdr[3:0] == 4'd0) && (r_flit_cnt == 3'd4)) ||
                         (w_is_write && (r_flit_cnt == 3'd5));

    // Decode outcome, evaluated in priority order while in ST_DECODE
    always_comb begin
        w_drop     = 1'b0;
        w_err      = 1'b0;
        w_access   = 1'b0;
        w_ed_write = 1'b0;
        w_rdata    = 16'h0000;
        if (r_hdr[5:4] != 2'b00) begin
            w_drop = 1'b1;
        end else if (!w_fmt_ok) begin
            w_err = 1'b1;
        end else if (r_addr <= 16'h0002) begin
            if (w_is_write) begin
                w_err = 1'b1;
            end else begin
                case (r_addr[1:0])
                    2'd0:    w_rdata = MOD_VENDOR;
                    2'd1:    w_rdata = MOD_TYPE;
                    default: w_rdata = MOD_VERSION;
                endcase
            end
        end else if (r_addr == 16'h0003) begin
            w_ed_write = w_is_write;
            w_rdata    = r_event_dest;
        end else if (r_addr < 16'h0200) begin
            w_err = 1'b1;
        end else begin
            w_access = 1'b1;
        end
    end

    assign w_tx_last_idx = (r_write || r_err) ? 2'd2 : 2'd3;
    assign w_tx_done     = out_ready && (r_tx_idx == w_tx_last_idx);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RX:     if (w_rx_accept && in_last) w_state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (w_drop)        w_state_nxt = ST_RX;
                else if (w_access) w_state_nxt = ST_ACCESS;
                else               w_state_nxt = ST_TX;
            end
            ST_ACCESS: if (reg_ack || reg_err) w_state_nxt = ST_TX;
            default:   if (w_tx_done) w_state_nxt = ST_RX;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RX;
            r_flit_cnt   <= 3'd0;
            r_src        <= 16'h0000;
            r_hdr        <= 6'd0;
            r_addr       <= 16'h0000;
            r_wdata      <= 16'h0000;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 16'h0000;
            r_tx_idx     <= 2'd0;
            r_event_dest <= 16'h0000;
            r_in_ready   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == ST_RX);
            case (r_state)
                ST_RX: begin
                    if (w_rx_accept) begin
                        r_flit_cnt <= in_first ? 3'd1 :
                                      ((r_flit_cnt == 3'd7) ? 3'd7 : r_flit_cnt + 3'd1);
                        // A restarted packet must not inherit the old header
                        if (in_first) r_hdr <= 6'd0;
                        case (w_rx_idx)
                            3'd1:    r_src   <= in_data;
                            3'd2:    r_hdr   <= in_data[15:10];
                            3'd3:    r_addr  <= in_data;
                            3'd4:    r_wdata <= in_data;
                            default: ;
                        endcase
                    end
                end
                ST_DECODE: begin
                    r_flit_cnt <= 3'd0;
                    r_write    <= w_is_write;
                    r_err      <= w_err;
                    r_rdata    <= w_rdata;
                    r_tx_idx   <= 2'd0;
                    if (w_ed_write) r_event_dest <= r_wdata;
                end
                ST_ACCESS: begin
                    if (reg_ack || reg_err) begin
                        r_err <= reg_err;
                        if (reg_ack && !reg_err) r_rdata <= reg_rdata;
                    end
                end
                default: begin
                    if (out_ready) r_tx_idx <= r_tx_idx + 2'd1;
                end
            endcase
        end
    end

    assign w_rsp_sub = r_write ? (r_err ? 4'd13 : 4'd12) : (r_err ? 4'd8 : 4'd0);

    always_comb begin
        out_data = 16'h0000;
        if (r_state == ST_TX) begin
            case (r_tx_idx)
                2'd0:    out_data = r_src;
                2'd1:    out_data = id;
                2'd2:    out_data = {2'b00, w_rsp_sub, 10'h000};
                default: out_data = r_rdata;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = (r_state == ST_TX);
    assign out_first   = out_valid && (r_tx_idx == 2'd0);
    assign out_last    = out_valid && (r_tx_idx == w_tx_last_idx);
    assign event_dest  = r_event_dest;
    assign reg_request = (r_state == ST_ACCESS);
    assign reg_write   = r_write;
    assign reg_addr    = r_addr;
    assign reg_wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dii_reg_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dii_reg_responder
// Description : Scoreboard bench for dii_reg_responder with a reference model
//               and a behavioural register-bus device.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dii_reg_responder;

    localparam logic [15:0] C_VENDOR  = 16'h0001;
    localparam logic [15:0] C_TYPE    = 16'h00C5;
    localparam logic [15:0] C_VERSION = 16'h0A07;
    localparam logic [15:0] C_ID      = 16'h0002;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        in_first = 1'b0, in_last = 1'b0, in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_first, out_last, out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] event_dest;
    logic        reg_request, reg_write;
    logic [15:0] reg_addr, reg_wdata;
    logic        reg_ack = 1'b0, reg_err = 1'b0;
    logic [15:0] reg_rdata = 16'h0;

    always #5 clk = ~clk;

    dii_reg_responder #(
        .MOD_VENDOR (C_VENDOR),
        .MOD_TYPE   (C_TYPE),
        .MOD_VERSION(C_VERSION)
    ) dut (
        .clk(clk), .rst_n(rst_n), .id(C_ID),
        .in_data(in_data), .in_first(in_first), .in_last(in_last),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_first(out_first), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .event_dest(event_dest),
        .reg_request(reg_request), .reg_write(reg_write),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
    );

    typedef struct { logic [15:0] d; bit f; bit l; } flit_t;
    typedef struct { bit w; logic [15:0] a; logic [15:0] wd; } acc_t;

    flit_t       exp_q[$];
    acc_t        acc_q[$];
    logic [15:0] pkt_q[$];
    logic [15:0] ref_mem [logic [15:0]];
    logic [15:0] dev_mem [logic [15:0]];
    logic [15:0] ref_ed = 16'h0;
    int          checks = 0;
    int          errors = 0;
    bit          stall_force = 1'b0;
    bit          hang = 1'b0;
    int          forced_lat = 0;

    function automatic logic [15:0] dflt(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: pops the scoreboard on every accepted flit
    initial begin
        flit_t       e;
        logic [15:0] held_d;
        bit          stalled;
        stalled = 1'b0;
        held_d  = 16'h0;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (stalled) check("stall_stable", out_data, held_d);
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_flit: got %h with nothing expected", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("flit_data", out_data, e.d);
                        check("flit_first", out_first, e.f);
                        check("flit_last", out_last, e.l);
                    end
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held_d  = out_data;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall_force ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Behavioural module register file on the local bus
    initial begin
        acc_t cur;
        int   held, lat;
        bit   busy;
        held = 0; lat = 0; busy = 1'b0;
        cur = '{1'b0, 16'h0, 16'h0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy = 1'b0; held = 0; reg_ack = 1'b0; reg_err = 1'b0;
            end else if (reg_request) begin
                if (!busy) begin
                    busy = 1'b1;
                    held = 0;
                    lat  = (forced_lat > 0) ? forced_lat : int'($urandom_range(1, 6));
                    if (acc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_access: got addr %h with nothing expected", reg_addr);
                        cur = '{reg_write, reg_addr, reg_wdata};
                    end else begin
                        cur = acc_q.pop_front();
                        check("acc_write", reg_write, cur.w);
                        check("acc_addr", reg_addr, cur.a);
                        if (cur.w) check("acc_wdata", reg_wdata, cur.wd);
                    end
                end else begin
                    check("acc_addr_stable", reg_addr, cur.a);
                end
                held++;
                reg_ack = 1'b0;
                reg_err = 1'b0;
                if (held == lat && !hang) begin
                    if (reg_addr >= 16'hF000) begin
                        reg_err   = 1'b1;
                        reg_ack   = reg_addr[0];
                        reg_rdata = 16'hDEAD;
                    end else begin
                        reg_ack = 1'b1;
                        if (reg_write) dev_mem[reg_addr] = reg_wdata;
                        else reg_rdata = dev_mem.exists(reg_addr) ? dev_mem[reg_addr] : dflt(reg_addr);
                    end
                end
            end else begin
                if (busy) begin
                    check("req_hold_cycles", held, lat);
                    busy = 1'b0;
                end
                reg_ack = 1'b0;
                reg_err = 1'b0;
            end
        end
    end

    task automatic send_flits(input bit with_last);
        int t;
        for (int i = 0; i < pkt_q.size(); i++) begin
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = pkt_q[i];
            in_first = (i == 0);
            in_last  = with_last && (i == pkt_q.size() - 1);
            t = 0;
            @(negedge clk);
            while (!in_ready && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got in_ready=0 expected 1 at %0t", $time);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    // Reference model: builds the request and predicts reply and bus access
    task automatic issue(input logic [15:0] src, input logic [1:0] typ, input logic [3:0] sub,
                         input logic [15:0] addr, input logic [15:0] wdata, input int n);
        int          cnt;
        bit          is_w, err;
        logic [15:0] rd, hdr;
        hdr = {typ, sub, 10'($urandom)};
        pkt_q = {};
        pkt_q.push_back(C_ID);
        pkt_q.push_back(src);
        pkt_q.push_back(hdr);
        pkt_q.push_back(addr);
        pkt_q.push_back(wdata);
        for (int i = 5; i < n; i++) pkt_q.push_back(16'($urandom));
        while (pkt_q.size() > n) void'(pkt_q.pop_back());
        if (typ == 2'd0) begin
            cnt  = (n > 7) ? 7 : n;
            is_w = (sub == 4'd4);
            err  = 1'b0;
            rd   = 16'h0;
            if (!((sub == 4'd0 && cnt == 4) || (sub == 4'd4 && cnt == 5))) err = 1'b1;
            else if (addr <= 16'd2) begin
                if (is_w) err = 1'b1;
                else rd = (addr == 16'd0) ? C_VENDOR : (addr == 16'd1) ? C_TYPE : C_VERSION;
            end else if (addr == 16'd3) begin
                if (is_w) ref_ed = wdata;
                else rd = ref_ed;
            end else if (addr < 16'h0200) err = 1'b1;
            else begin
                acc_q.push_back('{is_w, addr, wdata});
                if (addr >= 16'hF000) err = 1'b1;
                else if (is_w) ref_mem[addr] = wdata;
                else rd = ref_mem.exists(addr) ? ref_mem[addr] : dflt(addr);
            end
            exp_q.push_back('{d: src, f: 1'b1, l: 1'b0});
            exp_q.push_back('{d: C_ID, f: 1'b0, l: 1'b0});
            exp_q.push_back('{d: {2'b00, is_w ? (err ? 4'd13 : 4'd12) : (err ? 4'd8 : 4'd0), 10'h000},
                              f: 1'b0, l: (is_w || err)});
            if (!is_w && !err) exp_q.push_back('{d: rd, f: 1'b0, l: 1'b1});
        end
        send_flits(1'b1);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !in_ready) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending flits expected 0", exp_q.size());
        end
        check("event_dest", event_dest, ref_ed);
    endtask

    initial begin
        int          n;
        logic [1:0]  typ;
        logic [3:0]  sub;
        logic [15:0] addr;
        int          r;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_first", out_first, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, 16'h0);
        check("rst_event_dest", event_dest, 16'h0);
        check("rst_reg_request", reg_request, 1'b0);
        check("rst_reg_write", reg_write, 1'b0);
        check("rst_reg_addr", reg_addr, 16'h0);
        check("rst_reg_wdata", reg_wdata, 16'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Vendor read plus internal-register latency
        issue(16'h0000, 2'd0, 4'd0, 16'h0000, 16'h0, 4);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("internal_latency", n, 2);
        drain();

        issue(16'h0011, 2'd0, 4'd4, 16'h0003, 16'h1234, 5);
        drain();
        issue(16'h0011, 2'd0, 4'd0, 16'h0003, 16'h0, 4);
        drain();

        dev_mem[16'h0200] = 16'hBEEF;
        ref_mem[16'h0200] = 16'hBEEF;
        forced_lat = 5;
        issue(16'h0022, 2'd0, 4'd0, 16'h0200, 16'h0, 4);
        drain();
        forced_lat = 0;

        issue(16'h0044, 2'd0, 4'd4, 16'h0001, 16'h5555, 5);
        drain();
        issue(16'h0044, 2'd0, 4'd0, 16'h0100, 16'h0, 4);
        drain();
        issue(16'h0044, 2'd1, 4'd0, 16'h0000, 16'h0, 4);
        drain();
        issue(16'h0045, 2'd0, 4'd0, 16'hF001, 16'h0, 4);
        drain();
        issue(16'h0046, 2'd0, 4'd0, 16'h0000, 16'h0, 8);
        drain();

        // Abandoned partial packet followed by a restart
        pkt_q = {C_ID, 16'h0055, 16'h4000};
        send_flits(1'b0);
        issue(16'h0056, 2'd0, 4'd0, 16'h0001, 16'h0, 4);
        drain();

        stall_force = 1'b1;
        issue(16'h0066, 2'd0, 4'd0, 16'h0002, 16'h0, 4);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(posedge clk);
        stall_force = 1'b0;
        drain();

        // Reset in the middle of a bus access
        hang = 1'b1;
        issue(16'h0077, 2'd0, 4'd0, 16'h0300, 16'h0, 4);
        n = 0;
        while (!reg_request && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("access_started", reg_request, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_reg_request", reg_request, 1'b0);
        check("abort_in_ready", in_ready, 1'b0);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_event_dest", event_dest, 16'h0);
        exp_q.delete();
        acc_q.delete();
        ref_ed = 16'h0;
        hang = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        issue(16'h0078, 2'd0, 4'd0, 16'h0002, 16'h0, 4);
        drain();

        for (int k = 0; k < 80; k++) begin
            typ = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            r   = int'($urandom_range(0, 19));
            sub = (r < 9) ? 4'd0 : (r < 18) ? 4'd4 : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       addr = 16'($urandom_range(0, 3));
                1:       addr = 16'($urandom_range(4, 16'h01FF));
                2:       addr = 16'($urandom_range(16'h0200, 16'h020F));
                default: addr = 16'($urandom_range(16'hF000, 16'hF003));
            endcase
            n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(3, 9)) : ((sub == 4'd4) ? 5 : 4);
            issue(16'($urandom), typ, sub, addr, 16'($urandom), n);
            drain();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dii_reg_responder.md
Name: dii_reg_responder

Overview:
- Module-side endpoint of the DII register-access protocol.
- The host interface module issues register read/write request packets onto the debug ring. This block receives packets addressed to its debug module, serves the base registers internally, forwards module-specific addresses to a simple local register bus, and returns the response packet to the requester.
- Sits between a ring port and a debug module's register file.

Parameters:
MOD_VENDOR, 16'h0001, value returned at base register 0x0000
MOD_TYPE, 16'h0000, value returned at base register 0x0001
MOD_VERSION, 16'h0000, value returned at base register 0x0002

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id  in  16  this module's ring address
in_data  in  16  request flit
in_first  in  1  first flit of packet
in_last  in  1  last flit of packet
in_valid  in  1  request flit valid
in_ready  out  1  request flit accepted
out_data  out  16  response flit
out_first  out  1  first response flit
out_last  out  1  last response flit
out_valid  out  1  response flit valid
out_ready  in  1  ring accepts response flit
event_dest  out  16  base register 0x0003 (R/W)
reg_request  out  1  module register access strobe (level, held until ack/err)
reg_write  out  1  1=write, 0=read
reg_addr  out  16  module register address
reg_wdata  out  16  write data
reg_ack  in  1  access complete, success
reg_err  in  1  access complete, error
reg_rdata  in  16  read data, valid with reg_ack

Behaviour:
- Packet format, flit indices:
  - 0 = dest
  - 1 = src
  - 2 = header: type[15:14], type_sub[13:10], rest ignored
  - 3 = address
  - 4 = write data
- type 0 = REG. Only 16-bit accesses are supported: type_sub 0 = read, 4 = write.
- Reset values: in_ready=0, out_valid=0, out_first=0, out_last=0, out_data=0, event_dest=0, reg_request=0, reg_write=0, reg_addr=0, reg_wdata=0. FSM enters RX.
- RX:
  - in_ready=1.
  - Flit counter is cleared on in_first and saturates at 7.
  - Flits 1..4 are captured.
  - On in_last && in_valid, go to DECODE.
- DECODE (1 cycle), checks in priority order:
  - type != 0: drop the packet silently and return to RX.
  - type_sub not 0 or 4, or flit count not 4 (read) / 5 (write): error.
  - addr 0x0000–0x0002 read: PARAM value.
  - addr 0x0003: R/W event_dest.
  - Write to 0x0000–0x0002: error.
  - addr 0x0004–0x01FF: error.
  - addr >= 0x0200: go to ACCESS.
- ACCESS:
  - Assert reg_request with reg_write/reg_addr/reg_wdata stable until reg_ack or reg_err.
  - reg_request deasserts the cycle after completion.
  - reg_ack and reg_err together count as error.
  - No timeout.
- TX:
  - Flit 0 = captured src; flit 1 = id.
  - Flit 2 header type_sub:
    - read success = 0
    - read error = 8
    - write success = 12
    - write error = 13
  - Header type bits are 0 and the low bits are 0.
  - Flit 3 = read data, present on read success only. Response length is 4 or 3 flits.
  - out_first is set on flit 0 only; out_last on the final flit.
  - Flits advance only on out_valid && out_ready. out_data stays stable while stalled.
  - After the last flit is accepted, return to RX.
- in_ready=0 outside RX: at most one request is in flight, and there is no buffering beyond the capture registers.
- Latency: the first response flit is valid 2 cycles after the last request flit for internal registers.
- Boundary cases:
  - in_first arriving mid-packet restarts capture.
  - A packet longer than 5 flits saturates the counter and produces an error response.
  - Reset asserted mid-operation aborts immediately and returns all outputs to reset values.
- event_dest updates on the cycle the write is decoded.

Test Plan:
1. Read 0x0000 from src 0x0000, id=0x0002, MOD_VENDOR=0x0001 → response 0x0000, 0x0002, 0x0000, 0x0001. out_last on flit 3.
2. Write 0x0003 with 0x1234, then read it back → first response header 0x3000 (3 flits), event_dest=0x1234; read returns 0x1234.
3. Read 0x0200, module answers reg_ack after 5 cycles with reg_rdata=0xBEEF → reg_request held for exactly 5 cycles; response data 0xBEEF.
4. Write 0x0001 → write error header 0x3400. Read 0x0100 → read error header 0x2000. Type=1 packet → no response, in_ready returns high.
5. Hold out_ready=0 for 10 cycles during the response → flit 0 stays stable, nothing is lost. After release, all 4 flits arrive in order.
6. Assert rst_n low during ACCESS → reg_request=0 and in_ready=0 while in reset. After release, a fresh read of 0x0002 is answered correctly.
